// File: rtl/rr_sched_pkg.sv
// Shared types for the round-robin grant scheduler: FSM state encodings and
// the hold-counter width.
package rr_sched_pkg;

  localparam logic [1:0] ENC_IDLE    = 2'b00;
  localparam logic [1:0] ENC_GRANT   = 2'b01;
  localparam logic [1:0] ENC_RELEASE = 2'b10;

  // Wide enough for the largest legal hold limit (255).
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE    = ENC_IDLE,
    GRANT   = ENC_GRANT,
    RELEASE = ENC_RELEASE
  } state_t;

endpackage

// File: rtl/rr_pick_next.sv
// Rotating-priority search: finds the first set request bit starting one
// position after last_id, wrapping modulo NUM_REQ.
module rr_pick_next #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest hit wins
  // without needing a loop break.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value held and no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(last_id) + i) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin Moore scheduler sharing one resource among NUM_REQ requesters.
// Optional hold limit enabled by defining RR_HOLD_TIMEOUT_EN.
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_grant_scheduler: NUM_REQ or MAX_HOLD out of range");
  end

  state_t          state, state_nxt;
  logic [ID_W-1:0] owner, last_id;
  logic            pick_valid;
  logic [ID_W-1:0] pick_idx;
  logic            grant_load;
  logic            timeout_nxt, timeout_q;
  logic            hold_hit;

  rr_pick_next #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (req),
    .last_id(last_id),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

`ifdef RR_HOLD_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;

  assign hold_hit = (hold_cnt == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                hold_cnt <= '0;
    else if (grant_load)       hold_cnt <= HOLD_W'(1);
    else if (state == GRANT)   hold_cnt <= hold_cnt + HOLD_W'(1);
  end
`else
  assign hold_hit = 1'b0;
`endif

  // A dropped request takes precedence over the hold limit, so a coincident
  // release never reports a timeout.
  always_comb begin
    state_nxt   = state;
    grant_load  = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt  = GRANT;
          grant_load = 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          state_nxt = RELEASE;
        end else if (hold_hit) begin
          state_nxt   = RELEASE;
          timeout_nxt = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state flops use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      last_id   <= ID_W'(NUM_REQ - 1);
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      timeout_q <= timeout_nxt;
      if (grant_load) begin
        owner   <= pick_idx;
        last_id <= pick_idx;
      end
    end
  end

  // Outputs decode registered state only; req never reaches them directly.
  always_comb begin
    gnt = '0;
    if (state == GRANT) gnt[owner] = 1'b1;
  end

  assign gnt_id  = (state == GRANT || state == RELEASE) ? owner : '0;
  assign busy    = (state == GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed self-checking bench for rr_grant_scheduler (NUM_REQ=4, MAX_HOLD=8);
// covers both builds of RR_HOLD_TIMEOUT_EN.
module tb_rr_grant_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;

  rr_grant_scheduler #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                            input logic e_busy, input logic e_to);
    check({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    check({tag, ".gnt_id"},  32'(gnt_id),  32'(e_id));
    check({tag, ".busy"},    32'(busy),    32'(e_busy));
    check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    step();
    step();
    expect_out("in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Idle with no requests
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      expect_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Single requester: one-cycle latency, release, return to idle
    req = 4'b0100;
    #1;
    check("no_comb_grant", 32'(gnt), 32'h0);
    step();
    expect_out("single_g0", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      expect_out("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    expect_out("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    step();
    expect_out("single_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // All requesting: rotation 0,1,2,3,0 with two gnt=0 cycles per handoff
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      logic [3:0] oh;
      oh = 4'b0001 << order[t];
      step();
      expect_out("rr_g1", oh, order[t], 1'b1, 1'b0);
      step();
      expect_out("rr_g2", oh, order[t], 1'b1, 1'b0);
      req = 4'b1111 & ~oh;
      step();
      expect_out("rr_rel", 4'b0000, order[t], 1'b0, 1'b0);
      req = 4'b1111;
      step();
      expect_out("rr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Hold limit behaviour with two continuous requesters
    do_reset();
    req = 4'b0011;
`ifdef RR_HOLD_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      step();
      expect_out("to_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step();
    expect_out("to_rel", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    expect_out("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    expect_out("to_owner1", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int c = 0; c < 7; c++) begin
      step();
      expect_out("to_hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    // Drop coincides with the limit: normal release, no timeout
    req = 4'b0001;
    step();
    expect_out("to_coincide", 4'b0000, 2'd1, 1'b0, 1'b0);
`else
    for (int c = 0; c < 50; c++) begin
      step();
      expect_out("nolimit_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req = 4'b0010;
    step();
    expect_out("nolimit_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a tenure
    do_reset();
    req = 4'b1000;
    step();
    expect_out("ar_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    expect_out("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    step();
    expect_out("ar_regrant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    step();
    req = 4'b1001;
    step();
    expect_out("ar_pick0", 4'b0001, 2'd0, 1'b1, 1'b0);
    // Reset while owner 0 holds: last_id must restart so 0 wins again
    #3;
    reset = 1'b0;
    #1;
    check("ar2_async.gnt", 32'(gnt), 32'h0);
    req = 4'b0011;
    step();
    reset = 1'b1;
    step();
    expect_out("ar2_pick0", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
